uart_rx_param: RTL

//  Parametrised UART receiver; next generation of the rs232 RX path in the IR/UART link.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_sampler.sv | 40 ++++
 rtl/uart_rx_param.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t : receiver FSM states
//   PAR_*      : parity mode encodings as seen on ParMode (2'b11 also means none)
//   vote_idx() : tick counts within a bit period at which the three vote samples are taken
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2,
      WAIT_HI
   } rx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef struct packed {
      logic [15:0] first;
      logic [15:0] mid;
      logic [15:0] last;
   } vote_idx_t;

   // The vote is complete on the Tick carrying sample 'last'.
   function automatic vote_idx_t vote_idx(input int ovs);
      vote_idx_t v;
      v.first = 16'(ovs / 2 - 1);
      v.mid   = 16'(ovs / 2);
      v.last  = 16'(ovs / 2 + 1);
      return v;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial-line front end: 2-flop synchroniser and 3-sample majority vote.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset (line assumed idle/high)
//   tick_i  oversample enable; one sample taken per pulse
//   rx_i    asynchronous serial input
//   sync_o  synchronised line level
//   vote_o  majority of the last three samples, including the one taken on
//           the current tick_i cycle
module uart_rx_sampler (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic rx_i,
   output logic sync_o,
   output logic vote_o
);

   logic       meta_q;
   logic       sync_q;
   logic [1:0] hist_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         hist_q <= 2'b11;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         if (tick_i) hist_q <= {hist_q[0], sync_q};
      end
   end

   // The third sample is the synced bit being shifted in on this Tick, so the
   // decision is available in the same cycle as the last sample of the window.
   assign vote_o = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q) | (hist_q[0] & sync_q);
   assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with runtime frame format.
// Ports:
//   Clk, Rst   clock / asynchronous active-high reset
//   Tick       oversample enable, OVS pulses per bit
//   RxEn       arms start-bit detection
//   Rx         serial line (idles high)
//   NBits      data bits per frame (5..DATA_W, else DATA_W), latched at start
//   ParMode    00/11 none, 01 even, 10 odd, latched at start
//   TwoStop    check a second stop bit, latched at start
//   RxData     received word, right-justified
//   RxValid    1-Clk pulse when RxData/FrameErr/ParityErr update
//   FrameErr   a stop bit was sampled low
//   ParityErr  parity mismatch
//   Busy       receiver not idle
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OVS    = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Tick,
   input  logic              RxEn,
   input  logic              Rx,
   input  logic [3:0]        NBits,
   input  logic [1:0]        ParMode,
   input  logic              TwoStop,
   output logic [DATA_W-1:0] RxData,
   output logic              RxValid,
   output logic              FrameErr,
   output logic              ParityErr,
   output logic              Busy
);

   localparam int             CW       = $clog2(OVS);
   localparam vote_idx_t      VIDX     = vote_idx(OVS);
   localparam logic [CW-1:0]  CNT_VOTE = CW'(VIDX.last);
   localparam logic [CW-1:0]  CNT_LAST = CW'(OVS - 1);
   localparam logic [3:0]     NB_MAX   = 4'(DATA_W);

   logic rx_sync, rx_vote;

   uart_rx_sampler u_sampler (
      .clk_i  (Clk),
      .rst_i  (Rst),
      .tick_i (Tick),
      .rx_i   (Rx),
      .sync_o (rx_sync),
      .vote_o (rx_vote)
   );

   rx_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        bitcnt_q, bitcnt_d;
   logic [3:0]        nbits_q, nbits_d;
   logic [1:0]        par_mode_q, par_mode_d;
   logic              two_stop_q, two_stop_d;
   logic              bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_q, par_d;
   logic              ferr_q, ferr_d;
   logic              perr_q, perr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              parity_err_q, parity_err_d;

   logic at_vote, at_end, done, stop_bad;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bitcnt_q     <= '0;
         nbits_q      <= '0;
         par_mode_q   <= PAR_NONE;
         two_stop_q   <= 1'b0;
         bit_q        <= 1'b0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         ferr_q       <= 1'b0;
         perr_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bitcnt_q     <= bitcnt_d;
         nbits_q      <= nbits_d;
         par_mode_q   <= par_mode_d;
         two_stop_q   <= two_stop_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         ferr_q       <= ferr_d;
         perr_q       <= perr_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bitcnt_d     = bitcnt_q;
      nbits_d      = nbits_q;
      par_mode_d   = par_mode_q;
      two_stop_d   = two_stop_q;
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      ferr_d       = ferr_q;
      perr_d       = perr_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      at_vote      = (cnt_q == CNT_VOTE);
      at_end       = (cnt_q == CNT_LAST);
      done         = 1'b0;
      stop_bad     = ferr_q | ~rx_vote;

      if (Tick) begin
         if (state_q != IDLE) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
            // Mid-bit decision is kept until the bit boundary consumes it.
            if (at_vote) bit_d = rx_vote;
         end
         case (state_q)
            IDLE: begin
               if (RxEn && !rx_sync) begin
                  state_d    = START;
                  cnt_d      = '0;
                  bitcnt_d   = '0;
                  nbits_d    = (NBits < 4'd5 || NBits > NB_MAX) ? NB_MAX : NBits;
                  // 2'b11 is folded into "none" so later logic has one test.
                  par_mode_d = (ParMode == PAR_EVEN || ParMode == PAR_ODD) ? ParMode : PAR_NONE;
                  two_stop_d = TwoStop;
                  shreg_d    = '0;
                  par_d      = 1'b0;
                  ferr_d     = 1'b0;
                  perr_d     = 1'b0;
               end
            end
            START: begin
               if (at_vote && rx_vote) state_d = IDLE;
               else if (at_end)        state_d = DATA;
            end
            DATA: begin
               if (at_end) begin
                  // LSB arrives first: shift in from the top, right-justify on completion.
                  shreg_d  = {bit_q, shreg_q[DATA_W-1:1]};
                  par_d    = par_q ^ bit_q;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q + 4'd1 == nbits_q)
                     state_d = (par_mode_q != PAR_NONE) ? PARITY : STOP1;
               end
            end
            PARITY: begin
               if (at_end) begin
                  perr_d  = (par_q ^ bit_q) != (par_mode_q == PAR_ODD);
                  state_d = STOP1;
               end
            end
            STOP1: begin
               if (at_vote) begin
                  if (two_stop_q) ferr_d = stop_bad;
                  else            done   = 1'b1;
               end else if (at_end) begin
                  state_d = STOP2;
               end
            end
            STOP2: begin
               if (at_vote) done = 1'b1;
            end
            WAIT_HI: begin
               if (rx_vote) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      if (done) begin
         rx_valid_d   = 1'b1;
         rx_data_d    = shreg_q >> (NB_MAX - nbits_q);
         frame_err_d  = stop_bad;
         parity_err_d = perr_q;
         state_d      = stop_bad ? WAIT_HI : IDLE;
      end
   end

   assign RxData    = rx_data_q;
   assign RxValid   = rx_valid_q;
   assign FrameErr  = frame_err_q;
   assign ParityErr = parity_err_q;
   assign Busy      = (state_q != IDLE);

endmodule
